datamover_s2mm: RTL and testbench

Stream-to-memory-mapped write datamover: accepts packets (16–1600 bytes, `tkeep`-qualified) on an AXI-Stream slave and writes them to memory through an AXI4 memory-mapped write master using INCR bursts. One destination address per packet is taken from a separate address stream; with no address available the data stream is held not-ready. Generalises the single-burst mover with a configurable data width and maximum burst length, burst splitting at 4 KB boundaries, an internal burst buffer, write-response tracking and an optional per-packet status stream.

---
 rtl/datamover_s2mm_if.sv | 68 ++++++
 rtl/datamover_s2mm.sv | 188 ++++++++++++++++++
 tb/tb_datamover_s2mm.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/datamover_s2mm_if.sv
// Bus bundle for the stream-to-memory-mapped write datamover.
// Ports: packet stream (s_*), address stream (a_*), AXI4 write master (m_aw*/m_w*/m_b*), status stream (st_*).
// Option: DATAMOVER_STATUS_EN adds the st_* status stream; without it those signals do not exist.
// The master modport is the datamover's view; slave is the view of the surrounding system.
interface datamover_s2mm_if #(
   parameter int DATA_WIDTH = 32
);
   localparam int BYTES = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] s_data;
   logic [BYTES-1:0]      s_tkeep;
   logic                  s_tvalid;
   logic                  s_tlast;
   logic                  s_tready;

   logic [31:0]           a_data;
   logic                  a_tvalid;
   logic                  a_tready;

   logic [31:0]           m_awaddr;
   logic [7:0]            m_awlen;
   logic [2:0]            m_awsize;
   logic [1:0]            m_awburst;
   logic                  m_awvalid;
   logic                  m_awready;

   logic [DATA_WIDTH-1:0] m_wdata;
   logic [BYTES-1:0]      m_wstrb;
   logic                  m_wlast;
   logic                  m_wvalid;
   logic                  m_wready;

   logic [1:0]            m_bresp;
   logic                  m_bvalid;
   logic                  m_bready;

`ifdef DATAMOVER_STATUS_EN
   logic [31:0]           st_data;
   logic                  st_valid;
   logic                  st_ready;

   modport master (
      input  s_data, s_tkeep, s_tvalid, s_tlast, a_data, a_tvalid,
             m_awready, m_wready, m_bresp, m_bvalid, st_ready,
      output s_tready, a_tready, m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
             m_wdata, m_wstrb, m_wlast, m_wvalid, m_bready, st_data, st_valid
   );
   modport slave (
      output s_data, s_tkeep, s_tvalid, s_tlast, a_data, a_tvalid,
             m_awready, m_wready, m_bresp, m_bvalid, st_ready,
      input  s_tready, a_tready, m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
             m_wdata, m_wstrb, m_wlast, m_wvalid, m_bready, st_data, st_valid
   );
`else
   modport master (
      input  s_data, s_tkeep, s_tvalid, s_tlast, a_data, a_tvalid,
             m_awready, m_wready, m_bresp, m_bvalid,
      output s_tready, a_tready, m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
             m_wdata, m_wstrb, m_wlast, m_wvalid, m_bready
   );
   modport slave (
      output s_data, s_tkeep, s_tvalid, s_tlast, a_data, a_tvalid,
             m_awready, m_wready, m_bresp, m_bvalid,
      input  s_tready, a_tready, m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
             m_wdata, m_wstrb, m_wlast, m_wvalid, m_bready
   );
`endif
endinterface

// File: rtl/datamover_s2mm.sv
// Purpose: writes tkeep-qualified stream packets to memory as AXI4 INCR bursts, one address per packet, split at 4 KB.
// Latency: address accept -> s_tready next cycle; last buffered beat -> AW valid next cycle; W streams one beat/cycle.
// Backpressure: s_tready only while filling the burst buffer; every valid holds stable until its handshake.
// Ports: clk, reset_n (synchronous, active low), bus (datamover_s2mm_if.master).
// Option: DATAMOVER_STATUS_EN enables the per-packet status stream {error, 15'b0, byte_count}.
module datamover_s2mm #(
   parameter int DATA_WIDTH    = 32,
   parameter int MAX_BURST_LEN = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   datamover_s2mm_if.master bus
);
   localparam int BYTES    = DATA_WIDTH / 8;
   localparam int SIZE_LOG = $clog2(BYTES);
   localparam int IDX_W    = $clog2(MAX_BURST_LEN);
   localparam int CNT_W    = IDX_W + 1;

   typedef enum logic [2:0] {IDLE, FILL, ADDR, DATA, RESP, STATUS} state_t;
   state_t state, state_nxt;

   logic [31:0]           cur_addr;
   logic                  pkt_done;
   logic                  a_rdy;
   logic [CNT_W-1:0]      beats;
   logic [IDX_W-1:0]      rd_idx;
   logic [DATA_WIDTH-1:0] buf_data [MAX_BURST_LEN];
   logic [BYTES-1:0]      buf_keep [MAX_BURST_LEN];

   logic [12:0]           room_beats;
   logic [CNT_W-1:0]      limit;
   logic [CNT_W-1:0]      last_idx;
   logic                  s_rdy;
   logic                  s_hs;
   logic                  fill_end;
   logic                  w_last;

   // Beats left before the next 4 KB page; addresses are BYTES-aligned so this is never zero.
   assign room_beats = (13'd4096 - {1'b0, cur_addr[11:0]}) >> SIZE_LOG;
   assign limit      = (room_beats >= 13'(MAX_BURST_LEN)) ? CNT_W'(MAX_BURST_LEN)
                                                          : room_beats[CNT_W-1:0];
   assign last_idx   = beats - 1'b1;
   assign s_rdy      = (state == FILL) && (beats < limit);
   assign s_hs       = s_rdy && bus.s_tvalid;
   assign fill_end   = s_hs && (bus.s_tlast || (beats + 1'b1 == limit));
   assign w_last     = ({1'b0, rd_idx} == last_idx);

`ifdef DATAMOVER_STATUS_EN
   logic [15:0] byte_cnt;
   logic        err;
   logic [15:0] keep_bytes;
   logic [16:0] byte_sum;

   always_comb begin
      keep_bytes = '0;
      for (int i = 0; i < BYTES; i++) keep_bytes = keep_bytes + {15'b0, bus.s_tkeep[i]};
   end
   assign byte_sum = {1'b0, byte_cnt} + {1'b0, keep_bytes};

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         byte_cnt <= '0;
         err      <= 1'b0;
      end else if (state == IDLE && a_rdy && bus.a_tvalid) begin
         byte_cnt <= '0;
         err      <= 1'b0;
      end else if (s_hs) begin
         byte_cnt <= byte_sum[16] ? 16'hFFFF : byte_sum[15:0];
      end else if (state == RESP && bus.m_bvalid && bus.m_bresp != 2'b00) begin
         err <= 1'b1;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:   if (a_rdy && bus.a_tvalid) state_nxt = FILL;
         FILL:   if (fill_end) state_nxt = ADDR;
         ADDR:   if (bus.m_awready) state_nxt = DATA;
         DATA:   if (bus.m_wready && w_last) state_nxt = RESP;
         RESP: begin
            if (bus.m_bvalid) begin
               if (!pkt_done) state_nxt = FILL;
`ifdef DATAMOVER_STATUS_EN
               else           state_nxt = STATUS;
`else
               else           state_nxt = IDLE;
`endif
            end
         end
`ifdef DATAMOVER_STATUS_EN
         STATUS: if (bus.st_ready) state_nxt = IDLE;
`else
         STATUS: state_nxt = IDLE;
`endif
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs depend only on registered state, never on an incoming valid/ready.
   always_comb begin
      bus.s_tready  = s_rdy;
      bus.a_tready  = a_rdy;
      bus.m_awvalid = 1'b0;
      bus.m_awaddr  = '0;
      bus.m_awlen   = '0;
      bus.m_awsize  = '0;
      bus.m_awburst = '0;
      bus.m_wvalid  = 1'b0;
      bus.m_wdata   = '0;
      bus.m_wstrb   = '0;
      bus.m_wlast   = 1'b0;
      bus.m_bready  = 1'b0;
`ifdef DATAMOVER_STATUS_EN
      bus.st_valid  = 1'b0;
      bus.st_data   = '0;
`endif
      case (state)
         ADDR: begin
            bus.m_awvalid = 1'b1;
            bus.m_awaddr  = cur_addr;
            bus.m_awlen   = 8'(last_idx);
            bus.m_awsize  = 3'(SIZE_LOG);
            bus.m_awburst = 2'b01;
         end
         DATA: begin
            bus.m_wvalid = 1'b1;
            bus.m_wdata  = buf_data[rd_idx];
            bus.m_wstrb  = buf_keep[rd_idx];
            bus.m_wlast  = w_last;
         end
         RESP: bus.m_bready = 1'b1;
`ifdef DATAMOVER_STATUS_EN
         STATUS: begin
            bus.st_valid = 1'b1;
            bus.st_data  = {err, 15'b0, byte_cnt};
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cur_addr <= '0;
         pkt_done <= 1'b0;
         a_rdy    <= 1'b0;
         beats    <= '0;
         rd_idx   <= '0;
      end else begin
         // Registered so that the address accept is low throughout reset and drops right after a handshake.
         a_rdy <= (state_nxt == IDLE);
         case (state)
            IDLE: if (a_rdy && bus.a_tvalid) begin
               cur_addr <= bus.a_data;
               pkt_done <= 1'b0;
               beats    <= '0;
               rd_idx   <= '0;
            end
            FILL: if (s_hs) begin
               beats    <= beats + 1'b1;
               pkt_done <= bus.s_tlast;
            end
            DATA: if (bus.m_wready) rd_idx <= rd_idx + 1'b1;
            RESP: if (bus.m_bvalid) begin
               cur_addr <= cur_addr + ({{(32-CNT_W){1'b0}}, beats} << SIZE_LOG);
               beats    <= '0;
               rd_idx   <= '0;
            end
            default: ;
         endcase
      end
   end

   // Buffer contents need no reset: the beat count alone says what is valid.
   always_ff @(posedge clk) begin
      if (s_hs) begin
         buf_data[beats[IDX_W-1:0]] <= bus.s_data;
         buf_keep[beats[IDX_W-1:0]] <= bus.s_tkeep;
      end
   end
endmodule

// File: tb/tb_datamover_s2mm.sv
// Bench for datamover_s2mm (DATA_WIDTH=32, MAX_BURST_LEN=16): directed and randomized packets against
// a burst-list reference model; status checks are active when DATAMOVER_STATUS_EN is defined.
module tb_datamover_s2mm;
   logic clk;
   logic reset_n;
   int   checks;
   int   errors;

   datamover_s2mm_if #(.DATA_WIDTH(32)) bus ();

   datamover_s2mm #(.DATA_WIDTH(32), .MAX_BURST_LEN(16)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ctl"}, {bus.a_tready, bus.s_tready, bus.m_awvalid, bus.m_wvalid, bus.m_wlast, bus.m_bready}, 0);
      chk({tag, "_aw"}, {bus.m_awaddr, bus.m_awlen, bus.m_awsize, bus.m_awburst}, 0);
      chk({tag, "_w"}, {bus.m_wdata, bus.m_wstrb}, 0);
`ifdef DATAMOVER_STATUS_EN
      chk({tag, "_st"}, {bus.st_valid, bus.st_data}, 0);
`endif
   endtask

   // Model: a packet is a list of beats; bursts are cut at min(16, beats to the 4 KB page end, beats left).
   task automatic send_packet(input logic [31:0] addr, input int nbytes, input int err_burst,
                              input bit throttle, input bit pre_addr, input int zero_at);
      logic [31:0] pd[$];
      logic [3:0]  pk[$];
      logic [31:0] ea[$];
      int          el[$];
      logic [31:0] a, word, prev_awaddr;
      int nb, nbursts, idx, room, lim, len, rem, bytes;
      int si, aw_i, w_i, w_burst, w_in, b_i, fill_burst, fill_in;
      bit addr_sent, done, expect_aw, aw_pending;

      for (int i = 0; i * 4 < nbytes; i++) begin
         rem = nbytes - 4 * i;
         if (i == zero_at) begin
            word = $urandom;
            pd.push_back(word);
            pk.push_back(4'h0);
         end
         word = $urandom;
         pd.push_back(word);
         pk.push_back(rem >= 4 ? 4'hF : (4'hF >> (4 - rem)));
      end
      nb = pd.size();
      bytes = 0;
      foreach (pk[i]) bytes += $countones(pk[i]);
      if (bytes > 65535) bytes = 65535;
      a = addr;
      idx = 0;
      while (idx < nb) begin
         room = (4096 - int'(a[11:0])) / 4;
         lim  = (room < 16) ? room : 16;
         len  = ((nb - idx) < lim) ? (nb - idx) : lim;
         ea.push_back(a);
         el.push_back(len);
         a   = a + 32'(len * 4);
         idx = idx + len;
      end
      nbursts = ea.size();

      si = 0; aw_i = 0; w_i = 0; w_burst = 0; w_in = 0; b_i = 0; fill_burst = 0; fill_in = 0;
      addr_sent = pre_addr; done = 1'b0; expect_aw = 1'b0; aw_pending = 1'b0; prev_awaddr = '0;

      for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
         @(negedge clk);
         bus.a_tvalid  = !addr_sent;
         bus.a_data    = addr;
         bus.s_tvalid  = (si < nb) && (!throttle || $urandom_range(3) != 0);
         bus.s_data    = (si < nb) ? pd[si] : 32'h0;
         bus.s_tkeep   = (si < nb) ? pk[si] : 4'h0;
         bus.s_tlast   = (si == nb - 1);
         bus.m_awready = !throttle || ($urandom_range(1) == 1);
         bus.m_wready  = !throttle || ($urandom_range(3) != 0);
         bus.m_bvalid  = (b_i < w_burst) && (!throttle || $urandom_range(1) == 1);
         bus.m_bresp   = (b_i == err_burst) ? 2'b10 : 2'b00;
`ifdef DATAMOVER_STATUS_EN
         bus.st_ready  = !throttle || ($urandom_range(1) == 1);
`endif
         #1;
         chk("s_tready_no_addr", bus.s_tready & ~addr_sent, 1'b0);
         if (expect_aw) begin
            chk("aw_latency", bus.m_awvalid, 1'b1);
            expect_aw = 1'b0;
         end
         if (aw_pending) chk("aw_hold", {bus.m_awvalid, bus.m_awaddr}, {1'b1, prev_awaddr});
         if (!throttle && w_in > 0) chk("w_stream", bus.m_wvalid, 1'b1);

         if (bus.a_tvalid && bus.a_tready) addr_sent = 1'b1;
         if (bus.s_tvalid && bus.s_tready) begin
            si++;
            fill_in++;
            if (fill_burst < nbursts && fill_in == el[fill_burst]) begin
               expect_aw = 1'b1;
               fill_in = 0;
               fill_burst++;
            end
         end
         if (bus.m_wvalid && bus.m_wready) begin
            if (w_i < nb && w_burst < nbursts) begin
               chk("w_after_aw", aw_i > w_burst, 1'b1);
               chk("wdata", bus.m_wdata, pd[w_i]);
               chk("wstrb", bus.m_wstrb, pk[w_i]);
               chk("wlast", bus.m_wlast, w_in == el[w_burst] - 1);
               w_i++;
               w_in++;
               if (w_in == el[w_burst]) begin
                  w_in = 0;
                  w_burst++;
               end
            end else chk("w_extra_beat", w_i + 1, nb);
         end
         aw_pending = bus.m_awvalid && !bus.m_awready;
         prev_awaddr = bus.m_awaddr;
         if (bus.m_awvalid && bus.m_awready) begin
            if (aw_i < nbursts) begin
               chk("awaddr", bus.m_awaddr, ea[aw_i]);
               chk("awlen", bus.m_awlen, el[aw_i] - 1);
               chk("awsize_burst", {bus.m_awsize, bus.m_awburst}, 5'b010_01);
               aw_i++;
            end else chk("aw_extra", aw_i + 1, nbursts);
         end
         if (bus.m_bvalid && bus.m_bready) b_i++;
`ifdef DATAMOVER_STATUS_EN
         if (bus.st_valid && bus.st_ready) begin
            chk("status", bus.st_data,
                {(err_burst >= 0 && err_burst < nbursts), 15'b0, 16'(bytes)});
            done = 1'b1;
         end
`else
         if (b_i == nbursts) done = 1'b1;
`endif
      end
      chk("pkt_complete", done, 1'b1);
      chk("aw_count", aw_i, nbursts);
      chk("w_count", w_i, nb);
      @(negedge clk);
      bus.s_tvalid = 1'b0;
      bus.m_bvalid = 1'b0;
   endtask

   initial begin
      logic [31:0] r, addr;
      int          off, len, eb, sent;
      bit          got_a;

      checks = 0;
      errors = 0;
      reset_n = 1'b0;
      bus.s_data = '0; bus.s_tkeep = '0; bus.s_tvalid = 1'b0; bus.s_tlast = 1'b0;
      bus.a_data = '0; bus.a_tvalid = 1'b0;
      bus.m_awready = 1'b0; bus.m_wready = 1'b0; bus.m_bresp = 2'b00; bus.m_bvalid = 1'b0;
`ifdef DATAMOVER_STATUS_EN
      bus.st_ready = 1'b0;
`endif

      repeat (3) @(negedge clk);
      #1;
      chk_all_zero("reset");
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      #1;
      chk("a_tready_idle", bus.a_tready, 1'b1);

      // Data offered with no address: must be refused for 100 cycles.
      bus.s_tvalid = 1'b1; bus.s_data = 32'hDEAD_BEEF; bus.s_tkeep = 4'hF;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         #1;
         chk("hold_s_tready", bus.s_tready, 1'b0);
         chk("hold_awvalid", bus.m_awvalid, 1'b0);
      end
      @(negedge clk);
      bus.a_tvalid = 1'b1;
      bus.a_data = 32'h0000_5000;
      #1;
      chk("hold_a_tready", bus.a_tready, 1'b1);
      @(negedge clk);
      bus.a_tvalid = 1'b0;
      bus.s_tvalid = 1'b0;
      #1;
      chk("addr_to_tready", bus.s_tready, 1'b1);
      chk("a_tready_pulse", bus.a_tready, 1'b0);
      send_packet(32'h0000_5000, 40, -1, 1'b0, 1'b1, -1);

      send_packet(32'h0000_1000, 64, -1, 1'b0, 1'b0, -1);
      send_packet(32'h0002_0000, 1600, -1, 1'b1, 1'b0, -1);
      send_packet(32'h0000_0FF8, 24, -1, 1'b0, 1'b0, -1);
      send_packet(32'h0000_7000, 18, -1, 1'b1, 1'b0, -1);
      send_packet(32'h0000_8000, 128, 1, 1'b1, 1'b0, -1);
      send_packet(32'h0000_9000, 64, -1, 1'b1, 1'b0, -1);
      send_packet(32'h0000_A0F0, 40, -1, 1'b1, 1'b0, 3);
      send_packet(32'hFFFF_FFE0, 64, -1, 1'b0, 1'b0, -1);

      for (int p = 0; p < 6; p++) begin
         r    = $urandom;
         off  = $urandom_range(1, 40);
         addr = {r[31:12], 12'(4096 - 4 * off)};
         len  = $urandom_range(16, 300);
         eb   = -1;
         if ($urandom_range(1) == 1) eb = int'($urandom_range(3));
         send_packet(addr, len, eb, 1'b1, 1'b0, -1);
      end

      // Reset while the W channel is stalled mid-burst.
      sent = 0;
      got_a = 1'b0;
      for (int c = 0; c < 60 && !bus.m_wvalid; c++) begin
         @(negedge clk);
         bus.a_tvalid  = !got_a;
         bus.a_data    = 32'h0000_6000;
         bus.s_tvalid  = got_a && (sent < 3);
         bus.s_data    = $urandom;
         bus.s_tkeep   = 4'hF;
         bus.s_tlast   = (sent == 2);
         bus.m_awready = 1'b1;
         bus.m_wready  = 1'b0;
         #1;
         if (bus.a_tvalid && bus.a_tready) got_a = 1'b1;
         if (bus.s_tvalid && bus.s_tready) sent++;
      end
      chk("reached_data", bus.m_wvalid, 1'b1);
      reset_n = 1'b0;
      @(negedge clk);
      #1;
      chk_all_zero("reset_in_data");
      reset_n = 1'b1;
      @(negedge clk);
      #1;
      chk("post_reset_idle", {bus.a_tready, bus.s_tready, bus.m_wvalid}, 3'b100);
      send_packet(32'h0000_B000, 32, -1, 1'b1, 1'b0, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
